liteic_master_node_read: RTL and testbench

Master-side read node of the liteic crossbar, sitting directly upstream of the slave read nodes. It accepts one AXI-Lite read request at a time from its master port and decodes the target slave from address bits. It forwards the request over the crossbar request lines to that slave node, collects the {r_data, r_resp} response from the same node, and returns it on the master R channel. Unmapped or unconnected slaves are answered locally with DECERR.

---
 rtl/liteic_master_node_read.sv | 140 ++++++++++++++
 tb/tb_liteic_master_node_read.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/liteic_master_node_read.sv
// Master-side read node of the liteic crossbar: decodes one AR request, forwards it
// to the selected slave node, and returns the slave response (or a local DECERR) on R.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a new AR (once init_r is set)
// ST_REQ  | request valid on the selected slave slot, waiting for ready
// ST_WAIT | response ready on the selected slot, waiting for valid
// ST_RESP | R valid to the master, waiting for r_ready
module liteic_master_node_read #(
   parameter int NUM_SLAVE_SLOTS = 3,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SEL_LSB = 28,
   parameter int SEL_WIDTH = 2,
   parameter logic [NUM_SLAVE_SLOTS-1:0] RD_CONNECTIVITY = 3'b011
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic                        mst_ar_valid_i,
   input  logic [ADDR_WIDTH-1:0]       mst_ar_addr_i,
   output logic                        mst_ar_ready_o,
   output logic                        mst_r_valid_o,
   output logic [DATA_WIDTH-1:0]       mst_r_data_o,
   output logic [1:0]                  mst_r_resp_o,
   input  logic                        mst_r_ready_i,
   output logic [ADDR_WIDTH-1:0]       cbar_reqst_data_o,
   output logic [NUM_SLAVE_SLOTS-1:0]  cbar_reqst_val_o,
   input  logic [NUM_SLAVE_SLOTS-1:0]  cbar_reqst_rdy_i,
   input  logic [DATA_WIDTH+1:0]       cbar_resp_data_i [NUM_SLAVE_SLOTS],
   input  logic [NUM_SLAVE_SLOTS-1:0]  cbar_resp_val_i,
   output logic [NUM_SLAVE_SLOTS-1:0]  cbar_resp_rdy_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

   state_t                      state, state_nxt;
   logic [ADDR_WIDTH-1:0]       addr_r;
   logic [SEL_WIDTH-1:0]        idx_r;
   logic [SEL_WIDTH-1:0]        sel;
   logic [DATA_WIDTH-1:0]       rdata_r;
   logic [1:0]                  rresp_r;
   logic                        init_r;
   logic                        mapped;
   logic                        ar_hs;
   logic                        resp_hs;
   logic [NUM_SLAVE_SLOTS-1:0]  idx_oh;
   logic                        sel_reqst_rdy;
   logic                        sel_resp_val;
   logic [DATA_WIDTH+1:0]       sel_resp_data;

   assign sel = mst_ar_addr_i[SEL_LSB +: SEL_WIDTH];

   // Full-width compare: select values beyond the slot count never alias a real slot.
   always_comb begin
      mapped = 1'b0;
      for (int i = 0; i < NUM_SLAVE_SLOTS; i++) begin
         if (int'(sel) == i) mapped = RD_CONNECTIVITY[i];
      end
   end

   always_comb begin
      idx_oh = '0;
      sel_reqst_rdy = 1'b0;
      sel_resp_val = 1'b0;
      sel_resp_data = '0;
      for (int i = 0; i < NUM_SLAVE_SLOTS; i++) begin
         if (int'(idx_r) == i) begin
            idx_oh[i] = 1'b1;
            sel_reqst_rdy = cbar_reqst_rdy_i[i];
            sel_resp_val = cbar_resp_val_i[i];
            sel_resp_data = cbar_resp_data_i[i];
         end
      end
   end

   assign ar_hs = (state == ST_IDLE) && init_r && mst_ar_valid_i;
   assign resp_hs = (state == ST_WAIT) && sel_resp_val;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mst_ar_ready_o = 1'b0;
      mst_r_valid_o = 1'b0;
      cbar_reqst_val_o = '0;
      cbar_resp_rdy_o = '0;
      case (state)
         ST_IDLE: begin
            mst_ar_ready_o = init_r;
            if (ar_hs) state_nxt = mapped ? ST_REQ : ST_RESP;
         end
         ST_REQ: begin
            cbar_reqst_val_o = idx_oh;
            if (sel_reqst_rdy) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            cbar_resp_rdy_o = idx_oh;
            if (sel_resp_val) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            mst_r_valid_o = 1'b1;
            if (mst_r_ready_i) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         addr_r  <= '0;
         idx_r   <= '0;
         rdata_r <= '0;
         rresp_r <= 2'b00;
         init_r  <= 1'b0;
      end else begin
         init_r <= 1'b1;
         if (ar_hs) begin
            addr_r <= mst_ar_addr_i;
            idx_r  <= sel;
            if (!mapped) begin
               rdata_r <= '0;
               rresp_r <= 2'b11;
            end
         end
         if (resp_hs) begin
            rdata_r <= sel_resp_data[DATA_WIDTH+1:2];
            rresp_r <= sel_resp_data[1:0];
         end
      end
   end

   assign cbar_reqst_data_o = addr_r;
   assign mst_r_data_o = rdata_r;
   assign mst_r_resp_o = rresp_r;

endmodule

// File: tb/tb_liteic_master_node_read.sv
// Bench for liteic_master_node_read: master and slave-node stimulus driven on the falling
// edge, outputs checked against expectations derived from address decode rules.
module tb_liteic_master_node_read;

   localparam int NS = 3;
   localparam logic [2:0] CONN = 3'b011;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        mst_ar_valid_i = 1'b0;
   logic [31:0] mst_ar_addr_i = '0;
   logic        mst_ar_ready_o;
   logic        mst_r_valid_o;
   logic [31:0] mst_r_data_o;
   logic [1:0]  mst_r_resp_o;
   logic        mst_r_ready_i = 1'b0;
   logic [31:0] cbar_reqst_data_o;
   logic [2:0]  cbar_reqst_val_o;
   logic [2:0]  cbar_reqst_rdy_i = '0;
   logic [33:0] cbar_resp_data_i [NS];
   logic [2:0]  cbar_resp_val_i = '0;
   logic [2:0]  cbar_resp_rdy_o;

   int n_cmp = 0;
   int n_err = 0;

   liteic_master_node_read dut (
      .clk_i             (clk_i),
      .rstn_i            (rstn_i),
      .mst_ar_valid_i    (mst_ar_valid_i),
      .mst_ar_addr_i     (mst_ar_addr_i),
      .mst_ar_ready_o    (mst_ar_ready_o),
      .mst_r_valid_o     (mst_r_valid_o),
      .mst_r_data_o      (mst_r_data_o),
      .mst_r_resp_o      (mst_r_resp_o),
      .mst_r_ready_i     (mst_r_ready_i),
      .cbar_reqst_data_o (cbar_reqst_data_o),
      .cbar_reqst_val_o  (cbar_reqst_val_o),
      .cbar_reqst_rdy_i  (cbar_reqst_rdy_i),
      .cbar_resp_data_i  (cbar_resp_data_i),
      .cbar_resp_val_i   (cbar_resp_val_i),
      .cbar_resp_rdy_o   (cbar_resp_rdy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_mapped(input logic [31:0] addr);
      int s;
      s = int'(addr[29:28]);
      if (s >= NS) return 1'b0;
      return CONN[s];
   endfunction

   task automatic scramble_resp_data();
      for (int k = 0; k < NS; k++) cbar_resp_data_i[k] = {$urandom, 2'($urandom)};
   endtask

   // One complete read; expected results come from the decode model and the slave's reply.
   task automatic do_read(input logic [31:0] addr, input int rdy_dly, input int resp_dly,
                          input int rrdy_dly, input logic [31:0] sdata, input logic [1:0] sresp);
      int s;
      bit mapped;
      logic [2:0] oh;
      logic [31:0] exp_d;
      logic [1:0] exp_r;
      s = int'(addr[29:28]);
      mapped = model_mapped(addr);
      oh = mapped ? 3'(1 << s) : 3'b000;
      exp_d = mapped ? sdata : 32'h0;
      exp_r = mapped ? sresp : 2'b11;

      check_val("ar_ready_idle", mst_ar_ready_o, 1);
      check_val("r_valid_idle", mst_r_valid_o, 0);
      mst_ar_valid_i = 1'b1;
      mst_ar_addr_i = addr;
      mst_r_ready_i = 1'b0;
      @(negedge clk_i);
      mst_ar_valid_i = 1'b0;

      if (mapped) begin
         for (int i = 0; i <= rdy_dly; i++) begin
            check_val("reqst_val", cbar_reqst_val_o, oh);
            check_val("reqst_data", cbar_reqst_data_o, addr);
            check_val("resp_rdy_in_req", cbar_resp_rdy_o, 0);
            check_val("ar_ready_in_req", mst_ar_ready_o, 0);
            check_val("r_valid_in_req", mst_r_valid_o, 0);
            mst_ar_valid_i = 1'($urandom);
            mst_ar_addr_i = $urandom;
            mst_r_ready_i = 1'($urandom);
            cbar_reqst_rdy_i = 3'($urandom) & ~oh;
            if (i == rdy_dly) cbar_reqst_rdy_i = cbar_reqst_rdy_i | oh;
            @(negedge clk_i);
         end
         cbar_reqst_rdy_i = '0;
         for (int i = 0; i <= resp_dly; i++) begin
            check_val("resp_rdy", cbar_resp_rdy_o, oh);
            check_val("reqst_val_in_wait", cbar_reqst_val_o, 0);
            check_val("ar_ready_in_wait", mst_ar_ready_o, 0);
            check_val("r_valid_in_wait", mst_r_valid_o, 0);
            mst_ar_valid_i = 1'($urandom);
            mst_ar_addr_i = $urandom;
            mst_r_ready_i = 1'($urandom);
            scramble_resp_data();
            cbar_resp_val_i = 3'($urandom) & ~oh;
            cbar_reqst_rdy_i = 3'($urandom);
            if (i == resp_dly) begin
               cbar_resp_val_i = cbar_resp_val_i | oh;
               cbar_resp_data_i[s] = {sdata, sresp};
            end
            @(negedge clk_i);
         end
         cbar_resp_val_i = '0;
         cbar_reqst_rdy_i = '0;
         scramble_resp_data();
      end

      for (int i = 0; i <= rrdy_dly; i++) begin
         check_val("r_valid", mst_r_valid_o, 1);
         check_val("r_data", mst_r_data_o, exp_d);
         check_val("r_resp", mst_r_resp_o, exp_r);
         check_val("reqst_val_in_resp", cbar_reqst_val_o, 0);
         check_val("resp_rdy_in_resp", cbar_resp_rdy_o, 0);
         check_val("ar_ready_in_resp", mst_ar_ready_o, 0);
         mst_ar_valid_i = 1'($urandom);
         mst_ar_addr_i = $urandom;
         cbar_resp_val_i = 3'($urandom);
         mst_r_ready_i = (i == rrdy_dly);
         @(negedge clk_i);
      end
      mst_r_ready_i = 1'b0;
      mst_ar_valid_i = 1'b0;
      cbar_resp_val_i = '0;
      check_val("r_valid_after", mst_r_valid_o, 0);
      check_val("ar_ready_after", mst_ar_ready_o, 1);
   endtask

   initial begin
      scramble_resp_data();
      repeat (3) @(negedge clk_i);
      check_val("rst_ar_ready", mst_ar_ready_o, 0);
      check_val("rst_r_valid", mst_r_valid_o, 0);
      check_val("rst_r_data", mst_r_data_o, 0);
      check_val("rst_r_resp", mst_r_resp_o, 0);
      check_val("rst_reqst_val", cbar_reqst_val_o, 0);
      check_val("rst_reqst_data", cbar_reqst_data_o, 0);
      check_val("rst_resp_rdy", cbar_resp_rdy_o, 0);
      rstn_i = 1'b1;
      #1;
      check_val("ar_ready_first_cycle", mst_ar_ready_o, 0);
      @(negedge clk_i);
      check_val("ar_ready_after_init", mst_ar_ready_o, 1);
      check_val("reqst_val_after_init", cbar_reqst_val_o, 0);

      // zero-wait mapped read, backpressured read, unconnected and out-of-range slaves
      do_read(32'h1000_0040, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);
      do_read(32'h0000_1234, 5, 4, 3, 32'hCAFE_0001, 2'b10);
      do_read(32'h2000_0000, 0, 0, 0, 32'h1111_1111, 2'b00);
      do_read(32'h3000_0000, 0, 0, 2, 32'h2222_2222, 2'b00);

      // reset while waiting for a slave-0 response
      mst_ar_valid_i = 1'b1;
      mst_ar_addr_i = 32'h0000_0100;
      @(negedge clk_i);
      mst_ar_valid_i = 1'b0;
      cbar_reqst_rdy_i = 3'b001;
      @(negedge clk_i);
      cbar_reqst_rdy_i = '0;
      check_val("midrst_resp_rdy_pre", cbar_resp_rdy_o, 3'b001);
      #2 rstn_i = 1'b0;
      #1;
      check_val("midrst_resp_rdy", cbar_resp_rdy_o, 0);
      check_val("midrst_reqst_val", cbar_reqst_val_o, 0);
      check_val("midrst_reqst_data", cbar_reqst_data_o, 0);
      check_val("midrst_ar_ready", mst_ar_ready_o, 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      do_read(32'h0000_0200, 1, 2, 0, 32'h5A5A_A5A5, 2'b01);

      for (int t = 0; t < 60; t++) begin
         logic [31:0] a;
         a = $urandom;
         a[29:28] = 2'($urandom_range(0, 3));
         do_read(a, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                 $urandom, 2'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
